// File: rtl/seq_det_pkg.sv
// Shared constants, types and elaboration helpers for the multi-pattern
// serial sequence detector.
package seq_det_pkg;

  localparam int IDX_W     = 3;
  localparam int MAX_LEN   = 16;
  localparam int MAX_LANES = 8;

  typedef enum logic {
    MODE_NON_OVERLAP = 1'b0,
    MODE_OVERLAP     = 1'b1
  } det_mode_e;

  function automatic bit pat_len_ok(input int n);
    return (n >= 2) && (n <= MAX_LEN);
  endfunction

  function automatic bit num_pat_ok(input int n);
    return (n >= 1) && (n <= MAX_LANES);
  endfunction

  // Extracts lane idx from a packed reset-pattern vector, zero-extended.
  function automatic logic [MAX_LEN-1:0] rst_pat_slice(
    input logic [MAX_LEN*MAX_LANES-1:0] pats,
    input int                           idx,
    input int                           len
  );
    logic [MAX_LEN*MAX_LANES-1:0] sh;
    logic [MAX_LEN-1:0]           mask;
    sh   = pats >> (idx * len);
    mask = (MAX_LEN'(1) << len) - MAX_LEN'(1);
    return sh[MAX_LEN-1:0] & mask;
  endfunction

endpackage

// File: rtl/seq_detect_multi_if.sv
// Stream, configuration and result signals of the sequence detector.
interface seq_detect_multi_if
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 3,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8
);
  logic               din_valid;
  logic               din;
  logic               cfg_overlap;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic               clr_cnt;
  logic [NUM_PAT-1:0] match;
  logic               match_any;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output din_valid, din, cfg_overlap, cfg_we, cfg_idx, cfg_pattern, clr_cnt,
    input  match, match_any, match_cnt
  );

  modport slave (
    input  din_valid, din, cfg_overlap, cfg_we, cfg_idx, cfg_pattern, clr_cnt,
    output match, match_any, match_cnt
  );
endinterface

// File: rtl/seq_det_lane.sv
// One pattern lane: programmable pattern, fill counter and Moore match state.
module seq_det_lane
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] RST_PAT = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  det_mode_e          mode,
  input  logic               we,
  input  logic [PAT_LEN-1:0] wr_pat,
  input  logic [PAT_LEN-1:0] hist_nxt,
  output logic               match,
  output logic               match_nxt
);
  localparam int                FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q, pat_nxt;
  logic [FILL_W-1:0]  fill_q, fill_nxt, base, fill_inc;

  always_comb begin
    // Non-overlapping mode discards the bits that formed the last match.
    base      = (mode == MODE_NON_OVERLAP && match) ? '0 : fill_q;
    fill_inc  = (base == FULL) ? FULL : base + FILL_W'(1);
    pat_nxt   = pat_q;
    fill_nxt  = fill_q;
    match_nxt = match;
    if (we) begin
      pat_nxt   = wr_pat;
      fill_nxt  = '0;
      match_nxt = 1'b0;
    end else if (accept) begin
      fill_nxt  = fill_inc;
      match_nxt = (fill_inc == FULL) && (hist_nxt == pat_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= RST_PAT;
      fill_q <= '0;
      match  <= 1'b0;
    end else begin
      pat_q  <= pat_nxt;
      fill_q <= fill_nxt;
      match  <= match_nxt;
    end
  end

endmodule

// File: rtl/seq_detect_multi.sv
// Multi-lane Moore serial pattern detector: shared history register,
// NUM_PAT programmable lanes, registered match summary and saturating counter.
module seq_detect_multi
  import seq_det_pkg::*;
#(
  parameter int                         PAT_LEN      = 3,
  parameter int                         NUM_PAT      = 2,
  parameter int                         CNT_W        = 8,
  parameter logic [NUM_PAT*PAT_LEN-1:0] RST_PATTERNS = {3'b110, 3'b101}
) (
  input logic               clk,
  input logic               rst,
  seq_detect_multi_if.slave bus
);
  if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
    $error("seq_detect_multi: PAT_LEN must be 2..16");
  end
  if (!num_pat_ok(NUM_PAT)) begin : g_bad_num_pat
    $error("seq_detect_multi: NUM_PAT must be 1..8");
  end

  localparam logic [MAX_LEN*MAX_LANES-1:0] RST_ALL = (MAX_LEN*MAX_LANES)'(RST_PATTERNS);
  localparam logic [CNT_W-1:0]             CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] hist_q, hist_nxt;
  logic [NUM_PAT-1:0] match_q, match_nxt;
  logic               any_q;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               accept;
  det_mode_e          mode;

  assign accept   = bus.din_valid;
  assign mode     = det_mode_e'(bus.cfg_overlap);
  assign hist_nxt = accept ? {hist_q[PAT_LEN-2:0], bus.din} : hist_q;

  for (genvar i = 0; i < NUM_PAT; i++) begin : g_lane
    seq_det_lane #(
      .PAT_LEN (PAT_LEN),
      .RST_PAT (PAT_LEN'(rst_pat_slice(RST_ALL, i, PAT_LEN)))
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .accept    (accept),
      .mode      (mode),
      .we        (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))),
      .wr_pat    (bus.cfg_pattern),
      .hist_nxt  (hist_nxt),
      .match     (match_q[i]),
      .match_nxt (match_nxt[i])
    );
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (bus.clr_cnt) begin
      cnt_nxt = '0;
    end else if (accept && (|match_nxt) && (cnt_q != CNT_MAX)) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      any_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_nxt;
      any_q  <= |match_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_any = any_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_multi.sv
// Directed bench for seq_detect_multi with a per-lane bit-queue reference model.
module tb_seq_detect_multi;
  import seq_det_pkg::*;

  localparam int PAT_LEN = 3;
  localparam int NUM_PAT = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_detect_multi_if #(.PAT_LEN(PAT_LEN), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W)) bus ();

  seq_detect_multi #(
    .PAT_LEN      (PAT_LEN),
    .NUM_PAT      (NUM_PAT),
    .CNT_W        (CNT_W),
    .RST_PATTERNS (6'b110_101)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each lane keeps the bits it has seen since its last
  // restart; it matches when the newest PAT_LEN of them equal its pattern.
  logic [PAT_LEN-1:0] rst_pat [NUM_PAT] = '{3'b101, 3'b110};
  logic [PAT_LEN-1:0] m_pat   [NUM_PAT];
  bit                 lane_q  [NUM_PAT][$];
  logic [NUM_PAT-1:0] m_match = '0;
  logic               m_any   = 1'b0;
  int                 m_cnt   = 0;

  function automatic logic [PAT_LEN-1:0] tail_bits(input int i);
    logic [PAT_LEN-1:0] v = '0;
    foreach (lane_q[i][k]) v = {v[PAT_LEN-2:0], lane_q[i][k]};
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        lane_q[i].delete();
        m_pat[i] = rst_pat[i];
      end
      m_match = '0;
      m_any   = 1'b0;
      m_cnt   = 0;
    end else begin
      for (int i = 0; i < NUM_PAT; i++) begin
        if (bus.cfg_we && int'(bus.cfg_idx) == i) begin
          lane_q[i].delete();
          m_pat[i]   = bus.cfg_pattern;
          m_match[i] = 1'b0;
        end else if (bus.din_valid) begin
          if (!bus.cfg_overlap && m_match[i]) lane_q[i].delete();
          lane_q[i].push_back(bus.din);
          if (lane_q[i].size() > PAT_LEN) void'(lane_q[i].pop_front());
          m_match[i] = (lane_q[i].size() == PAT_LEN) && (tail_bits(i) == m_pat[i]);
        end
      end
      m_any = |m_match;
      if (bus.clr_cnt) m_cnt = 0;
      else if (bus.din_valid && (|m_match) && m_cnt < CNT_MAX) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_match", 32'(bus.match), 32'(m_match));
      chk("cyc_any", 32'(bus.match_any), 32'(m_any));
      chk("cyc_cnt", 32'(bus.match_cnt), 32'(m_cnt));
    end
  end

  task automatic send(input bit b);
    bus.din_valid = 1'b1;
    bus.din       = b;
    @(posedge clk); #2;
    bus.din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic cfg_write(input int idx, input logic [PAT_LEN-1:0] p);
    bus.cfg_we      = 1'b1;
    bus.cfg_idx     = 3'(idx);
    bus.cfg_pattern = p;
    @(posedge clk); #2;
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #3;
    chk("rst_match", 32'(bus.match), 32'h0);
    chk("rst_any", 32'(bus.match_any), 32'h0);
    chk("rst_cnt", 32'(bus.match_cnt), 32'h0);
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    bus.din_valid = 1'b0; bus.din = 1'b0; bus.cfg_overlap = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_pattern = '0; bus.clr_cnt = 1'b0;
    @(posedge clk); #2;
    pulse_rst();
    chk_en = 1'b1;

    // Legacy patterns, overlapping
    send(1); send(1); send(0);
    chk("t1_bit3", 32'(bus.match), 32'h2);
    send(1);
    chk("t1_bit4", 32'(bus.match), 32'h1);
    chk("t1_cnt", 32'(bus.match_cnt), 32'd2);
    chk("t1_any", 32'(bus.match_any), 32'h1);

    // 10101 overlapping
    pulse_rst();
    send(1); send(0); send(1);
    chk("t2o_bit3", 32'(bus.match), 32'h1);
    send(0);
    chk("t2o_bit4", 32'(bus.match), 32'h0);
    send(1);
    chk("t2o_bit5", 32'(bus.match), 32'h1);
    chk("t2o_cnt", 32'(bus.match_cnt), 32'd2);

    // 10101 non-overlapping
    pulse_rst();
    bus.cfg_overlap = 1'b0;
    send(1); send(0); send(1);
    chk("t2n_bit3", 32'(bus.match), 32'h1);
    send(0); send(1);
    chk("t2n_bit5", 32'(bus.match), 32'h0);
    chk("t2n_cnt", 32'(bus.match_cnt), 32'd1);

    // Gaps in din_valid
    pulse_rst();
    bus.cfg_overlap = 1'b1;
    send(1); idle(3); send(0);
    chk("t3_mid", 32'(bus.match), 32'h0);
    idle(2); send(1);
    chk("t3_end", 32'(bus.match), 32'h1);
    idle(3);
    chk("t3_hold", 32'(bus.match), 32'h1);

    // Config write concurrent with an accepted bit, then out-of-range index
    pulse_rst();
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'd1; bus.cfg_pattern = 3'b111;
    send(1);
    bus.cfg_we = 1'b0;
    chk("t4_wr", 32'(bus.match), 32'h0);
    send(1); send(1);
    chk("t4_two", 32'(bus.match), 32'h0);
    send(1);
    chk("t4_three", 32'(bus.match), 32'h2);
    cfg_write(5, 3'b000);
    chk("t4_idx5", 32'(bus.match), 32'h2);
    send(1);
    chk("t4_idx5_bit", 32'(bus.match), 32'h2);
    chk("t4_cnt", 32'(bus.match_cnt), 32'd2);

    // Counter saturation and clear priority
    pulse_rst();
    cfg_write(1, 3'b111);
    repeat (7) send(1);
    chk("t5_sat", 32'(bus.match_cnt), 32'd3);
    bus.clr_cnt = 1'b1;
    send(1);
    bus.clr_cnt = 1'b0;
    chk("t5_clr", 32'(bus.match_cnt), 32'd0);
    chk("t5_clr_match", 32'(bus.match), 32'h2);
    send(1);
    chk("t5_after", 32'(bus.match_cnt), 32'd1);

    // Reset mid-pattern restores reset patterns
    pulse_rst();
    cfg_write(0, 3'b111);
    send(1); send(1);
    pulse_rst();
    send(0);
    chk("t6_fresh", 32'(bus.match), 32'h0);
    send(1); send(0); send(1);
    chk("t6_restored", 32'(bus.match), 32'h1);

    idle(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_multi.md
# seq_detect_multi

Parametrised Moore serial-pattern detector and next generation of the fixed two-pattern (101/110) detector. Watches a serial bit stream for NUM_PAT runtime-programmable patterns of PAT_LEN bits each, with selectable overlapping or non-overlapping detection and a saturating match counter. Sits behind a serial front end; matches feed downstream control/interrupt logic.

## Interface
- PAT_LEN, 3, pattern length in bits (2..16)
- NUM_PAT, 2, number of pattern lanes (1..8)
- CNT_W, 8, match counter width
- RST_PATTERNS, {3'b110, 3'b101}, NUM_PAT*PAT_LEN reset patterns, lane i at [i*PAT_LEN +: PAT_LEN] (default reproduces legacy 101/110)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- din_valid  in  1  din is accepted this cycle
- din  in  1  serial data bit
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled on every accepted bit
- cfg_we  in  1  pattern write strobe
- cfg_idx  in  3  lane to write
- cfg_pattern  in  PAT_LEN  new pattern; bit PAT_LEN-1 is the earliest received
- clr_cnt  in  1  synchronous counter clear
- match  out  NUM_PAT  per-lane Moore match state
- match_any  out  1  OR of match, registered
- match_cnt  out  CNT_W  saturating count of accepted bits completing ≥1 match

## Operation
- Shared history hist[PAT_LEN-1:0]: on accepted bit, hist' = {hist[PAT_LEN-2:0], din}.
- Per lane i: pattern pat_i, fill counter fill_i (0..PAT_LEN, saturating), match register match_i.
- Accepted bit, lane i: base = (!cfg_overlap && match_i) ? 0 : fill_i; fill_i' = min(base+1, PAT_LEN); match_i' = (fill_i' == PAT_LEN) && (hist' == pat_i).
- No accepted bit: hist, fill, match hold (Moore: match is pure state, held across din_valid=0).
- Non-overlap: after a match, the lane requires PAT_LEN fresh bits before matching again; other lanes unaffected.
- Config write with cfg_idx < NUM_PAT: pat_idx' = cfg_pattern, fill_idx' = 0, match_idx' = 0. cfg_idx ≥ NUM_PAT: ignored.
- Simultaneous cfg_we and din_valid: written lane takes the config action (bit not counted for it); hist still shifts; other lanes process the bit normally.
- Counter: +1 per accepted bit where any match_i' is 1 (not per lane); saturates at 2^CNT_W-1. clr_cnt forces 0 and wins over a simultaneous increment.
- Reset: hist=0, all fill=0, match=0, match_any=0, match_cnt=0, patterns = RST_PATTERNS.

## Timing
- Latency: match/match_any/match_cnt update on the clk edge that samples the completing bit; visible the following cycle.
- match_any is registered from match_i' (same cycle as match), not combinational from match.
- Config write effective next cycle; the first bit accepted after it is fill count 1.
- Reset asserted mid-stream clears everything immediately (async); first accepted bit after deassertion starts a fresh fill.
- No combinational input-to-output paths.

## Structure
- Package seq_det_pkg: lane index width constant, parameter-legality checks (PAT_LEN 2..16, NUM_PAT 1..8), helper for RST_PATTERNS slicing.
- Sub-module seq_det_lane, generated NUM_PAT times: holds pat, fill, match; inputs hist', accept, overlap, write strobe; outputs match_i'. Top owns hist, match_any, counter.

## Test plan
- Legacy defaults, overlap=1, stream 1,1,0,1 -> match=2'b10 after bit 3, 2'b01 after bit 4; match_cnt=2.
- Overlap=1, pattern 101 on lane 0, stream 1,0,1,0,1 -> lane 0 matches after bits 3 and 5, match_cnt=2; overlap=0 same stream -> match after bit 3 only, cnt=1.
- din_valid gaps: 1,(3 idle),0,(2 idle),1 -> match_i high only after the final accepted bit, held through subsequent idle cycles.
- Write lane 1 = 3'b111 concurrently with an accepted bit -> lane 1 match=0, fill restarts; after 1,1,1 lane 1 matches; write cfg_idx=5 -> no change.
- CNT_W=2: five matching bits -> cnt saturates at 3; clr_cnt with simultaneous match -> 0.
- rst pulse mid-pattern (after 1,1) then 0 -> no match; outputs 0 during/after reset; patterns restored to RST_PATTERNS.
